// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller.
// States, opcodes, mux selects and ALU operation codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        LUI,
        ALUWB,
        JAL,
        JALR,
        JALR_WB,
        BRANCH
    } state_t;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        FUNCT
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALURES = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_REG   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Immediate format implied by the opcode; I-type for anything else.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] s;
        s = IMM_I;
        case (op)
            OP_STORE:         s = IMM_S;
            OP_BRANCH:        s = IMM_B;
            OP_JAL:           s = IMM_J;
            OP_LUI, OP_AUIPC: s = IMM_U;
            default:          s = IMM_I;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder for the multicycle controller.
// Maps the coarse alu_op plus IR fields onto an ALU code.
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alu_control
);

    // funct3 selects the operation; funct7b5 splits add/sub and srl/sra
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ADD: alu_control = ALU_ADD;
            SUB: alu_control = ALU_SUB;
            FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller.
// Sequences each instruction and drives all datapath selects and enables.
module control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic [1:0] result_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       adr_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal_instr
);

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    taken;
    logic    ir_w, pc_w, reg_w, mem_w, ill_w;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Branch condition from ALU flags
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next state and datapath controls
    always_comb begin
        state_d    = state_q;
        result_sel = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        adr_src    = 1'b0;
        imm_src    = IMM_I;
        alu_op     = ADD;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ill_w      = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_sel = RES_ALURES;
                ir_w       = mem_ready;
                pc_w       = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = imm_sel(op);
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECUTER;
                    OP_I:              state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = ALUWB;
                    default: begin
                        ill_w   = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_sel = RES_DATA;
                reg_w      = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_a = SRCA_REG;
                alu_op    = FUNCT;
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = FUNCT;
                state_d   = ALUWB;
            end
            LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_w      = 1'b1;
                state_d   = ALUWB;
            end
            JALR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                result_sel = RES_ALURES;
                pc_w       = 1'b1;
                state_d    = JALR_WB;
            end
            JALR_WB: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_sel = RES_ALURES;
                reg_w      = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a = SRCA_REG;
                alu_op    = SUB;
                pc_w      = taken;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Enables are forced low while reset is held, even mid-instruction
    assign ir_write      = ir_w  & ~rst;
    assign pc_write      = pc_w  & ~rst;
    assign reg_write     = reg_w & ~rst;
    assign mem_write     = mem_w & ~rst;
    assign illegal_instr = ill_w & ~rst;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm.
// Per-instruction step model plus directed literal checks.
module tb_control_fsm;

    logic       clk, rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, ltu, mem_ready;
    logic [1:0] result_sel, alu_src_a, alu_src_b;
    logic       adr_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       ir_write, pc_write, reg_write, mem_write, illegal_instr;

    control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .lt            (lt),
        .ltu           (ltu),
        .mem_ready     (mem_ready),
        .result_sel    (result_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .adr_src       (adr_src),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .mem_write     (mem_write),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int C_R = 0, C_I = 1, C_LUI = 2, C_AUIPC = 3, C_LOAD = 4;
    localparam int C_STORE = 5, C_BR = 6, C_JAL = 7, C_JALR = 8, C_ILL = 9;

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input int c);
        case (c)
            C_STORE:         return 3'd1;
            C_BR:            return 3'd2;
            C_JAL:           return 3'd3;
            C_LUI, C_AUIPC:  return 3'd4;
            default:         return 3'd0;
        endcase
    endfunction

    // kind: 0 add, 1 sub, 2 by funct fields
    function automatic logic [3:0] ref_alu(input int kind, input logic [2:0] f3,
                                           input logic f7, input logic o5);
        int tbl [8];
        tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
        if (kind == 0) return 4'd0;
        if (kind == 1) return 4'd1;
        if (f3 == 3'd0 && o5 && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd7;
        return 4'(tbl[f3]);
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic z,
                                     input logic l, input logic lu);
        bit c;
        case (f3[2:1])
            2'b00:   c = z;
            2'b10:   c = l;
            2'b11:   c = lu;
            default: return 1'b0;
        endcase
        return f3[0] ? !c : c;
    endfunction

    int m_step = 0;
    int m_cls  = C_ILL;
    bit started = 0;

    // Expected outputs for the current instruction step
    task automatic model_eval(output logic [18:0] e, output bit adv, output bit last);
        logic [1:0] rs, a, b;
        logic       adr;
        logic [2:0] imm;
        int         ak, k;
        bit         irw, pcw, regw, memw, ill;
        rs = 0; a = 0; b = 0; adr = 0; imm = 0; ak = 0;
        irw = 0; pcw = 0; regw = 0; memw = 0; ill = 0;
        adv = 1; last = 0;
        k = m_step - 2;
        if (m_step == 0) begin
            b = 2; rs = 2; irw = mem_ready; pcw = mem_ready; adv = mem_ready;
        end else if (m_step == 1) begin
            a = 1; b = 1; imm = imm_of(cls_of(op));
            ill = (cls_of(op) == C_ILL); last = ill;
        end else begin
            case (m_cls)
                C_R:     if (k == 0) begin a = 2; ak = 2; end
                         else begin regw = 1; last = 1; end
                C_I:     if (k == 0) begin a = 2; b = 1; ak = 2; end
                         else begin regw = 1; last = 1; end
                C_LUI:   if (k == 0) begin a = 3; b = 1; end
                         else begin regw = 1; last = 1; end
                C_AUIPC: begin regw = 1; last = 1; end
                C_LOAD:  if (k == 0) begin a = 2; b = 1; end
                         else if (k == 1) begin adr = 1; adv = mem_ready; end
                         else begin rs = 1; regw = 1; last = 1; end
                C_STORE: if (k == 0) begin a = 2; b = 1; end
                         else begin adr = 1; memw = 1; adv = mem_ready; last = mem_ready; end
                C_BR:    begin
                             a = 2; ak = 1; last = 1;
                             pcw = ref_taken(funct3, zero, lt, ltu);
                         end
                C_JAL:   if (k == 0) begin a = 1; b = 2; pcw = 1; end
                         else begin regw = 1; last = 1; end
                C_JALR:  if (k == 0) begin a = 2; b = 1; rs = 2; pcw = 1; end
                         else begin a = 1; b = 2; rs = 2; regw = 1; last = 1; end
                default: last = 1;
            endcase
        end
        e = {rs, a, b, adr, imm, ref_alu(ak, funct3, funct7b5, op[5]),
             irw, pcw, regw, memw, ill};
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [18:0] e, act;
        bit adv, last;
        if (rst) started = 1;
        if (started) begin
            act = {result_sel, alu_src_a, alu_src_b, adr_src, imm_src, alu_control,
                   ir_write, pc_write, reg_write, mem_write, illegal_instr};
            n_cmp++;
            if (rst) begin
                if (act[4:0] !== 5'b0) begin
                    n_bad++;
                    $display("FAIL reset_enables t=%0t got %b expected 00000", $time, act[4:0]);
                end
                m_step = 0;
            end else begin
                model_eval(e, adv, last);
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL model_cycle t=%0t step=%0d got %h expected %h",
                             $time, m_step, act, e);
                end
                if (m_step == 1) m_cls = cls_of(op);
                if (last) m_step = 0;
                else if (adv) m_step++;
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    int rec_rs [32], rec_a [32], rec_b [32], rec_adr [32], rec_alu [32];
    int rec_pcw [32], rec_regw [32], rec_memw [32], rec_ill [32];

    task automatic rec(input int i);
        rec_rs[i]   = int'(result_sel);
        rec_a[i]    = int'(alu_src_a);
        rec_b[i]    = int'(alu_src_b);
        rec_adr[i]  = int'(adr_src);
        rec_alu[i]  = int'(alu_control);
        rec_pcw[i]  = int'(pc_write);
        rec_regw[i] = int'(reg_write);
        rec_memw[i] = int'(mem_write);
        rec_ill[i]  = int'(illegal_instr);
    endtask

    // Runs one instruction from FETCH until FETCH is seen again
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic l, input logic lu,
                       input int mem_at, input int nwait, input int rst_at,
                       output int cnt);
        int idx;
        #1;
        op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
        mem_ready = 1'b1; rst = 1'b0;
        rec(0);
        cnt = -1;
        for (idx = 1; idx < 20; idx++) begin
            @(posedge clk);
            #1;
            mem_ready = !(idx >= mem_at && idx < mem_at + nwait);
            rst = (idx == rst_at);
            @(negedge clk);
            rec(idx);
            if (alu_src_a == 2'd0 && alu_src_b == 2'd2) begin
                cnt = idx;
                break;
            end
        end
        if (cnt < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL fetch_timeout got no FETCH expected FETCH within 20 cycles");
        end
    endtask

    int cnt;

    initial begin
        rst = 1'b1; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'd0;
        funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        repeat (2) begin
            @(negedge clk);
            lit("rst_ir_write", int'(ir_write), 0);
            lit("rst_pc_write", int'(pc_write), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        lit("first_ir_write", int'(ir_write), 1);
        lit("first_pc_write", int'(pc_write), 1);

        run(7'b0110011, 3'd0, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("add_len", cnt, 4);
        lit("add_alu", rec_alu[2], 0);
        lit("add_wb_regw", rec_regw[3], 1);
        lit("add_wb_rs", rec_rs[3], 0);

        run(7'b0110011, 3'd0, 1'b1, 0, 0, 0, -1, 0, -1, cnt);
        lit("sub_alu", rec_alu[2], 1);

        run(7'b0010011, 3'd0, 1'b1, 0, 0, 0, -1, 0, -1, cnt);
        lit("addi_f7_alu", rec_alu[2], 0);

        run(7'b0010011, 3'd5, 1'b1, 0, 0, 0, -1, 0, -1, cnt);
        lit("srai_alu", rec_alu[2], 7);

        run(7'b0000011, 3'd2, 1'b0, 0, 0, 0, 3, 3, -1, cnt);
        lit("lw_len", cnt, 8);
        for (int i = 3; i < 7; i++) begin
            lit("lw_wait_adr", rec_adr[i], 1);
            lit("lw_wait_regw", rec_regw[i], 0);
        end
        lit("lw_wb_rs", rec_rs[7], 1);
        lit("lw_wb_regw", rec_regw[7], 1);

        run(7'b1100011, 3'd1, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("bne_nz_pcw", rec_pcw[2], 1);
        lit("br_len", cnt, 3);
        run(7'b1100011, 3'd1, 1'b0, 1, 0, 0, -1, 0, -1, cnt);
        lit("bne_z_pcw", rec_pcw[2], 0);
        run(7'b1100011, 3'd7, 1'b0, 0, 0, 1, -1, 0, -1, cnt);
        lit("bgeu_ltu_pcw", rec_pcw[2], 0);
        run(7'b1100011, 3'd4, 1'b0, 0, 1, 0, -1, 0, -1, cnt);
        lit("blt_lt_pcw", rec_pcw[2], 1);

        run(7'b1100111, 3'd0, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("jalr_pcw", rec_pcw[2], 1);
        lit("jalr_rs", rec_rs[2], 2);
        lit("jalr_wb_regw", rec_regw[3], 1);
        lit("jalr_wb_a", rec_a[3], 1);
        lit("jalr_wb_b", rec_b[3], 2);

        run(7'b1101111, 3'd0, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("jal_len", cnt, 4);
        run(7'b0010111, 3'd0, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("auipc_len", cnt, 3);
        run(7'b0110111, 3'd0, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("lui_a", rec_a[2], 3);

        run(7'b1111111, 3'd0, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("ill_len", cnt, 2);
        lit("ill_pulse", rec_ill[1], 1);
        lit("ill_fetch_clear", rec_ill[0], 0);

        run(7'b0100011, 3'd2, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("sw_len", cnt, 4);
        lit("sw_memw", rec_memw[3], 1);
        run(7'b0100011, 3'd2, 1'b0, 0, 0, 0, 3, 1, 3, cnt);
        lit("sw_rst_memw", rec_memw[3], 0);
        lit("sw_rst_len", cnt, 4);

        run(7'b0110011, 3'd7, 1'b0, 0, 0, 0, -1, 0, -1, cnt);
        lit("and_alu", rec_alu[2], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
